// File: rtl/bm_sample_sink_pkg.sv
// Shared sample format and helpers for the bm_rng sample sink.
// Samples are signed s4.11 two's complement: 1 sign, 4 integer, 11 fraction bits.
package bm_sample_sink_pkg;

    localparam int BM_SAMPLE_W = 16;
    localparam int BM_FRAC_W   = 11;

    typedef logic signed [BM_SAMPLE_W-1:0] sample_t;

    // The square is never negative. Its largest value is (-32768)^2 = 2^30,
    // so it always fits in 32 unsigned bits.
    function automatic logic [2*BM_SAMPLE_W-1:0] sample_sq(input sample_t x);
        logic signed [2*BM_SAMPLE_W-1:0] p;
        p = x * x;
        return p;
    endfunction

endpackage

// File: rtl/bm_sample_sink_if.sv
// Pair input from bm_rng and the serialised 16-bit valid/ready output stream.
interface bm_sample_sink_if;
    import bm_sample_sink_pkg::*;

    sample_t x0_in;
    sample_t x1_in;
    logic    in_valid;
    sample_t out_data;
    logic    out_valid;
    logic    out_ready;

    modport master (
        output x0_in, x1_in, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  x0_in, x1_in, in_valid, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/bm_sample_fifo.sv
// FIFO with two writes and one read per cycle, a registered output stage and an occupancy count.
// The count includes the entry currently presented on rd_data.
module bm_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data0,
    input  logic [W-1:0]             wr_data1,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next, count_after_pop;
    logic [W-1:0]  rd_data_reg;
    logic          rd_valid_reg;
    logic          pop;

    assign pop = rd_en & rd_valid_reg;

    always_comb begin
        rd_ptr_next     = rd_ptr_reg + PW'(pop);
        count_after_pop = count_reg - CW'(pop);
        count_next      = count_after_pop + (wr_en ? CW'(2) : CW'(0));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg]          <= wr_data0;
            mem[wr_ptr_reg + PW'(1)] <= wr_data1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PW'(2);
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rd_valid_reg <= (count_next != '0);
            // When the FIFO would be empty after the pop, the next head is the
            // x0 being written this cycle, which is not in mem yet.
            if (count_next != '0) begin
                if (count_after_pop == '0)
                    rd_data_reg <= wr_data0;
                else
                    rd_data_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign count    = count_reg;

endmodule

// File: rtl/bm_sample_sink.sv
// Consumer of bm_rng pairs: serialises each pair into a 16-bit stream through a FIFO,
// counts dropped pairs, and accumulates the sum and sum of squares over each window.
module bm_sample_sink
    import bm_sample_sink_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIN_LOG2 = 10,
    parameter int DROP_W   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          scan_in0,
    input  logic                          scan_en,
    input  logic                          test_mode,
    output logic                          scan_out0,
    bm_sample_sink_if.slave               smp,
    output logic [DROP_W-1:0]             drop_cnt,
    output logic signed [16+WIN_LOG2-1:0] stats_sum,
    output logic [32+WIN_LOG2-1:0]        stats_sumsq,
    output logic                          stats_valid
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SUM_W = BM_SAMPLE_W + WIN_LOG2;
    localparam int SQ_W  = 2*BM_SAMPLE_W + WIN_LOG2;
    // Sample count held by the window just before its closing pair arrives.
    localparam logic [WIN_LOG2-1:0] LAST_CNT = WIN_LOG2'((1 << WIN_LOG2) - 2);

    logic [CW-1:0]           fifo_count;
    logic                    accept;
    logic [DROP_W-1:0]       drop_cnt_reg;
    logic signed [SUM_W-1:0] acc_sum_reg, pair_sum, stats_sum_reg;
    logic [SQ_W-1:0]         acc_sq_reg, pair_sq, stats_sumsq_reg;
    logic                    stats_valid_reg;
    logic [WIN_LOG2-1:0]     sample_cnt_reg;
    logic                    win_close;
    logic                    unused_dft;

    assign unused_dft = scan_in0 ^ scan_en ^ test_mode;
    assign scan_out0  = 1'b0;

    // A pair is accepted only if both samples fit. Any pop in the same cycle
    // is not counted as freeing space.
    assign accept = smp.in_valid && (fifo_count <= CW'(DEPTH - 2));

    bm_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (BM_SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_data0 (smp.x0_in),
        .wr_data1 (smp.x1_in),
        .rd_en    (smp.out_ready),
        .rd_data  (smp.out_data),
        .rd_valid (smp.out_valid),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt_reg <= '0;
        else if (smp.in_valid && !accept && (drop_cnt_reg != '1))
            drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
    end

    always_comb begin
        pair_sum  = {{WIN_LOG2{smp.x0_in[BM_SAMPLE_W-1]}}, smp.x0_in}
                  + {{WIN_LOG2{smp.x1_in[BM_SAMPLE_W-1]}}, smp.x1_in};
        pair_sq   = {{WIN_LOG2{1'b0}}, sample_sq(smp.x0_in)}
                  + {{WIN_LOG2{1'b0}}, sample_sq(smp.x1_in)};
        win_close = (sample_cnt_reg == LAST_CNT);
    end

    // Statistics see every pair, including those the FIFO had to drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_sum_reg     <= '0;
            acc_sq_reg      <= '0;
            sample_cnt_reg  <= '0;
            stats_sum_reg   <= '0;
            stats_sumsq_reg <= '0;
            stats_valid_reg <= 1'b0;
        end else begin
            stats_valid_reg <= 1'b0;
            if (smp.in_valid) begin
                sample_cnt_reg <= sample_cnt_reg + WIN_LOG2'(2);
                if (win_close) begin
                    stats_sum_reg   <= acc_sum_reg + pair_sum;
                    stats_sumsq_reg <= acc_sq_reg + pair_sq;
                    stats_valid_reg <= 1'b1;
                    acc_sum_reg     <= '0;
                    acc_sq_reg      <= '0;
                end else begin
                    acc_sum_reg <= acc_sum_reg + pair_sum;
                    acc_sq_reg  <= acc_sq_reg + pair_sq;
                end
            end
        end
    end

    assign drop_cnt    = drop_cnt_reg;
    assign stats_sum   = stats_sum_reg;
    assign stats_sumsq = stats_sumsq_reg;
    assign stats_valid = stats_valid_reg;

endmodule

// File: tb/tb_bm_sample_sink.sv
// Directed bench for bm_sample_sink with DEPTH=8 and WIN_LOG2=2, so each window is 2 pairs.
module tb_bm_sample_sink;
    import bm_sample_sink_pkg::*;

    localparam int DEPTH    = 8;
    localparam int WIN_LOG2 = 2;
    localparam int DROP_W   = 16;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          scan_in0, scan_en, test_mode, scan_out0;
    logic [DROP_W-1:0]             drop_cnt;
    logic signed [16+WIN_LOG2-1:0] stats_sum;
    logic [32+WIN_LOG2-1:0]        stats_sumsq;
    logic                          stats_valid;

    int checks = 0;
    int errors = 0;

    bm_sample_sink_if smp();

    bm_sample_sink #(
        .DEPTH    (DEPTH),
        .WIN_LOG2 (WIN_LOG2),
        .DROP_W   (DROP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (scan_in0),
        .scan_en     (scan_en),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .smp         (smp),
        .drop_cnt    (drop_cnt),
        .stats_sum   (stats_sum),
        .stats_sumsq (stats_sumsq),
        .stats_valid (stats_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
        smp.in_valid = v;
        smp.x0_in    = a;
        smp.x1_in    = b;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0);
        smp.out_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 16'(k * 3), 16'(k));
            tick;
        end
        drive(1'b0, 16'h0, 16'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (smp.out_valid !== 1'b0 || smp.out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_out valid=%b data=%h required valid=0 data=0000", smp.out_valid, smp.out_data);
        end
        checks++;
        if (drop_cnt !== 16'd0 || stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_sv drop=%0d sv=%b required 0 0", drop_cnt, stats_valid);
        end
        checks++;
        if (stats_sum !== 18'sd0 || stats_sumsq !== 34'd0 || scan_out0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_stats sum=%0d sumsq=%0d scan_out0=%b required 0 0 0", stats_sum, stats_sumsq, scan_out0);
        end
        tick;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (smp.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid cycle %0d got %b required 0", c, smp.out_valid);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_ordering;
        logic [15:0] exp_s [4];
        exp_s[0] = 16'h0800; exp_s[1] = 16'hF800; exp_s[2] = 16'h7FFF; exp_s[3] = 16'h8000;
        do_reset;
        smp.out_ready = 1'b1;
        drive(1'b1, 16'h0800, 16'hF800);
        tick;
        drive(1'b1, 16'h7FFF, 16'h8000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (smp.out_valid !== 1'b1 || smp.out_data !== exp_s[i]) begin
                errors++;
                $display("FAIL order_%0d valid=%b data=%h required 1 %h", i, smp.out_valid, smp.out_data, exp_s[i]);
            end else
                $display("order sample %0d data=%h", i, smp.out_data);
            tick;
            drive(1'b0, 16'h0, 16'h0);
        end
        checks++;
        if (smp.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_empty valid=%b required 0", smp.out_valid);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] exp_s [8];
        do_reset;
        for (int k = 1; k <= 4; k++) begin
            exp_s[2*k-2] = 16'(k * 256);
            exp_s[2*k-1] = 16'(k);
        end
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 16'(k * 256), 16'(k));
            tick;
            $display("overflow push pair %0d drop_cnt=%0d", k, drop_cnt);
            checks++;
            if (smp.out_valid !== 1'b1 || smp.out_data !== 16'h0100) begin
                errors++;
                $display("FAIL hold_%0d valid=%b data=%h required 1 0100", k, smp.out_valid, smp.out_data);
            end
            if (k == 5) begin
                checks++;
                if (drop_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL drop_first got %0d required 1", drop_cnt);
                end
            end
        end
        drive(1'b0, 16'h0, 16'h0);
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL drop_full got %0d required 2", drop_cnt);
        end
        // Pairs 5 and 6 were both dropped but still form the third window.
        checks++;
        if (stats_valid !== 1'b1 || stats_sum !== 18'sd2827 || stats_sumsq !== 34'd3997757) begin
            errors++;
            $display("FAIL drop_stats sv=%b sum=%0d sumsq=%0d required 1 2827 3997757", stats_valid, stats_sum, stats_sumsq);
        end
        smp.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (smp.out_valid !== 1'b1 || smp.out_data !== exp_s[i]) begin
                errors++;
                $display("FAIL ovf_drain_%0d valid=%b data=%h required 1 %h", i, smp.out_valid, smp.out_data, exp_s[i]);
            end
            tick;
        end
        checks++;
        if (smp.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty valid=%b required 0", smp.out_valid);
        end
    endtask

    task automatic test_simultaneous;
        logic [15:0] exp_s [6];
        exp_s[0] = 16'h0B00; exp_s[1] = 16'h0B01; exp_s[2] = 16'h0C00;
        exp_s[3] = 16'h0C01; exp_s[4] = 16'h0D00; exp_s[5] = 16'h0D01;
        do_reset;
        drive(1'b1, 16'h0A00, 16'h0A01); tick;
        drive(1'b1, 16'h0B00, 16'h0B01); tick;
        drive(1'b1, 16'h0C00, 16'h0C01); tick;
        // Six entries held: pushing D while popping A0 must be accepted.
        smp.out_ready = 1'b1;
        drive(1'b1, 16'h0D00, 16'h0D01);
        tick;
        $display("simul push D with pop: drop_cnt=%0d data=%h", drop_cnt, smp.out_data);
        checks++;
        if (drop_cnt !== 16'd0 || smp.out_data !== 16'h0A01) begin
            errors++;
            $display("FAIL simul_accept drop=%0d data=%h required 0 0a01", drop_cnt, smp.out_data);
        end
        // Seven entries held: a same-cycle pop does not make room for a pair.
        drive(1'b1, 16'h0E00, 16'h0E01);
        tick;
        drive(1'b0, 16'h0, 16'h0);
        $display("simul push E with pop: drop_cnt=%0d", drop_cnt);
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL simul_drop got %0d required 1", drop_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (smp.out_valid !== 1'b1 || smp.out_data !== exp_s[i]) begin
                errors++;
                $display("FAIL simul_drain_%0d valid=%b data=%h required 1 %h", i, smp.out_valid, smp.out_data, exp_s[i]);
            end
            tick;
        end
        checks++;
        if (smp.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty valid=%b required 0", smp.out_valid);
        end
    endtask

    task automatic test_stats;
        do_reset;
        smp.out_ready = 1'b1;
        drive(1'b1, 16'h0001, 16'hFFFF);
        tick;
        checks++;
        if (stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL stats_early sv=%b required 0", stats_valid);
        end
        drive(1'b1, 16'd256, 16'd512);
        tick;
        drive(1'b0, 16'h0, 16'h0);
        $display("stats window 1 sv=%b sum=%0d sumsq=%0d", stats_valid, stats_sum, stats_sumsq);
        checks++;
        if (stats_valid !== 1'b1 || stats_sum !== 18'sd768 || stats_sumsq !== 34'd327682) begin
            errors++;
            $display("FAIL stats_w1 sv=%b sum=%0d sumsq=%0d required 1 768 327682", stats_valid, stats_sum, stats_sumsq);
        end
        tick;
        checks++;
        if (stats_valid !== 1'b0 || stats_sum !== 18'sd768 || stats_sumsq !== 34'd327682) begin
            errors++;
            $display("FAIL stats_hold sv=%b sum=%0d sumsq=%0d required 0 768 327682", stats_valid, stats_sum, stats_sumsq);
        end
        // Extreme negative samples with a gap inside the window.
        drive(1'b1, 16'h8000, 16'h8000);
        tick;
        drive(1'b0, 16'h0, 16'h0);
        tick;
        checks++;
        if (stats_valid !== 1'b0 || stats_sum !== 18'sd768) begin
            errors++;
            $display("FAIL stats_mid sv=%b sum=%0d required 0 768", stats_valid, stats_sum);
        end
        drive(1'b1, 16'h0000, 16'h0000);
        tick;
        drive(1'b0, 16'h0, 16'h0);
        $display("stats window 2 sv=%b sum=%0d sumsq=%0d", stats_valid, stats_sum, stats_sumsq);
        checks++;
        if (stats_valid !== 1'b1 || stats_sum !== -18'sd65536 || stats_sumsq !== 34'd2147483648) begin
            errors++;
            $display("FAIL stats_w2 sv=%b sum=%0d sumsq=%0d required 1 -65536 2147483648", stats_valid, stats_sum, stats_sumsq);
        end
    endtask

    task automatic test_continuous;
        logic [15:0] exp_q [$];
        logic [15:0] a, b, e;
        do_reset;
        smp.out_ready = 1'b1;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400 && cyc % 2 == 0) begin
                a = 16'($urandom);
                b = 16'($urandom);
                drive(1'b1, a, b);
                exp_q.push_back(a);
                exp_q.push_back(b);
            end else
                drive(1'b0, 16'h0, 16'h0);
            tick;
            if (smp.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cont_extra cycle %0d data=%h required no sample", cyc, smp.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (smp.out_data !== e) begin
                        errors++;
                        $display("FAIL cont_data cycle %0d got %h required %h", cyc, smp.out_data, e);
                    end
                end
            end
        end
        checks++;
        if (drop_cnt !== 16'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL cont_end drop=%0d left=%0d required 0 0", drop_cnt, exp_q.size());
        end
        $display("continuous stream complete drop_cnt=%0d", drop_cnt);
    endtask

    initial begin
        reset     = 1'b1;
        scan_in0  = 1'b0;
        scan_en   = 1'b0;
        test_mode = 1'b0;
        smp.out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        test_reset;
        test_ordering;
        test_overflow;
        test_simultaneous;
        test_stats;
        test_continuous;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
